// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB register front end for the UART datapath.
// Holds the control and baud registers, buffers received bytes in a small
// RX FIFO, and hands TX bytes to the serializer with a start/busy handshake.
module uart_apb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd27
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        uart_en,
    output logic [15:0] baud_div,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_BAUD   = 4'd1;
    localparam logic [3:0] REG_RXDATA = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;
    localparam logic [3:0] REG_TXDATA = 4'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_FIRST,
        TX_WAIT
    } tx_state_t;

    // Architectural state
    logic            uart_en_q,   uart_en_d;
    logic            rx_irq_en_q, rx_irq_en_d;
    logic            tx_irq_en_q, tx_irq_en_d;
    logic [15:0]     baud_q,      baud_d;
    logic [AW-1:0]   wptr_q,      wptr_d;
    logic [AW-1:0]   rptr_q,      rptr_d;
    logic [CW-1:0]   count_q,     count_d;
    logic            overrun_q,   overrun_d;
    tx_state_t       tx_state_q,  tx_state_d;
    logic [7:0]      tx_data_q,   tx_data_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    // Decoded bus activity and FIFO control
    logic        acc, wr_acc, rd_acc;
    logic [3:0]  idx;
    logic        fifo_empty, fifo_full, tx_active;
    logic        flush, pop, push_req, push, drop, tx_launch;
    logic [7:0]  head;
    logic [31:0] status_w;
    logic [31:0] rdata;
    logic        err;

    // Bus decode, FIFO handshakes and status word
    always_comb begin
        acc        = PSEL & PENABLE;
        wr_acc     = acc & PWRITE;
        rd_acc     = acc & ~PWRITE;
        idx        = PADDR[3:0];
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        tx_active  = (tx_state_q != TX_IDLE);
        head       = mem_q[rptr_q];
        flush      = wr_acc && (idx == REG_CTRL) && PWDATA[3];
        pop        = rd_acc && (idx == REG_RXDATA) && !fifo_empty;
        // Flush wins over a coincident receive; a full FIFO still accepts a
        // byte when the same edge pops one.
        push_req   = rx_done && uart_en_q && !flush;
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
        tx_launch  = wr_acc && (idx == REG_TXDATA) && !tx_active && uart_en_q;
        status_w   = {24'b0, 4'(count_q), tx_active, overrun_q, fifo_full, !fifo_empty};
    end

    // Register-file writes and FIFO pointer/count next state
    always_comb begin
        uart_en_d   = uart_en_q;
        rx_irq_en_d = rx_irq_en_q;
        tx_irq_en_d = tx_irq_en_q;
        baud_d      = baud_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;

        if (wr_acc && (idx == REG_CTRL)) begin
            uart_en_d   = PWDATA[0];
            rx_irq_en_d = PWDATA[1];
            tx_irq_en_d = PWDATA[2];
        end
        if (wr_acc && (idx == REG_BAUD)) begin
            baud_d = PWDATA[15:0];
        end

        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (wr_acc && (idx == REG_STATUS) && PWDATA[2]) overrun_d = 1'b0;
            if (drop) overrun_d = 1'b1;
        end
    end

    // TX launch sequencer: START pulses once, first WAIT cycle ignores tx_busy
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_launch) begin
                    tx_state_d = TX_START;
                    tx_data_d  = PWDATA[7:0];
                end
            end
            TX_START:      tx_state_d = TX_WAIT_FIRST;
            TX_WAIT_FIRST: tx_state_d = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) tx_state_d = TX_IDLE;
            end
            default:       tx_state_d = TX_IDLE;
        endcase
    end

    // Read mux and error decode for the current access
    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (idx)
            REG_CTRL:   rdata = {29'b0, tx_irq_en_q, rx_irq_en_q, uart_en_q};
            REG_BAUD:   rdata = {16'b0, baud_q};
            REG_RXDATA: begin
                if (PWRITE || fifo_empty) err = 1'b1;
                else                      rdata = {24'b0, head};
            end
            REG_STATUS: rdata = status_w;
            REG_TXDATA: begin
                if (!PWRITE)                       err = 1'b1;
                else if (tx_active || !uart_en_q)  err = 1'b1;
            end
            default:    err = 1'b1;
        endcase
        PRDATA   = rd_acc ? rdata : '0;
        PSLVERR  = acc ? err : 1'b0;
        PREADY   = acc;
        tx_data  = tx_data_q;
        tx_start = (tx_state_q == TX_START);
        uart_en  = uart_en_q;
        baud_div = baud_q;
        irq      = uart_en_q & ((rx_irq_en_q & !fifo_empty) |
                                (tx_irq_en_q & !tx_active) | overrun_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            uart_en_q   <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            baud_q      <= BAUD_RST;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= '0;
        end else begin
            uart_en_q   <= uart_en_d;
            rx_irq_en_q <= rx_irq_en_d;
            tx_irq_en_q <= tx_irq_en_d;
            baud_q      <= baud_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            tx_state_q  <= tx_state_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge PCLK) begin
        if (!PRESET && push) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
module tb_uart_apb_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        uart_en;
    logic [15:0] baud_div;
    logic        irq;

    uart_apb_ctrl #(.FIFO_DEPTH(4), .BAUD_RST(16'd27)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .rx_data(rx_data),
        .rx_done(rx_done), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .uart_en(uart_en), .baud_div(baud_div), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       nm;
        bit          is_rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       apb_q[$];
    logic [7:0] tx_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every APB access phase and every tx_start pulse is matched
    // against the head of the corresponding expectation queue.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
                chk("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = apb_q.pop_front();
                chk({e.nm, "_pready"}, {31'b0, PREADY}, 32'd1);
                chk({e.nm, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
                if (e.is_rd) chk({e.nm, "_prdata"}, PRDATA, e.data);
            end
        end
        if (tx_start) begin
            if (tx_q.size() == 0) begin
                chk("tx_start_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] b;
                b = tx_q.pop_front();
                chk("tx_data_at_start", {24'b0, tx_data}, {24'b0, b});
            end
        end
    end

    task automatic apb(input bit wr, input logic [3:0] idx, input logic [31:0] wdat,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm,
                       input bit with_rx = 1'b0, input logic [7:0] rxb = 8'h00);
        exp_t e;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = 32'h4000_0000 | {28'b0, idx}; PWDATA = wdat;
        e.nm = nm; e.is_rd = !wr; e.data = exp_rd; e.err = exp_err;
        apb_q.push_back(e);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        rx_done = with_rx; rx_data = rxb;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rx_done = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input logic err, input string nm);
        apb(1'b0, idx, 32'h0, exp, err, nm);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] dat, input logic err, input string nm);
        apb(1'b1, idx, dat, 32'h0, err, nm);
    endtask

    task automatic rx(input logic [7:0] b);
        @(posedge PCLK); #1;
        rx_done = 1'b1; rx_data = b;
        @(posedge PCLK); #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        PRESET = 1'b0;
        idle(1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
        chk("rst_baud_div", {16'b0, baud_div}, 32'd27);
        chk("rst_uart_en", {31'b0, uart_en}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        rd(4'd1, 32'd27, 1'b0, "rst_baud");
        rd(4'd3, 32'd0, 1'b0, "rst_status");
        rd(4'd0, 32'd0, 1'b0, "rst_ctrl");

        // Basic receive path
        wr(4'd0, 32'h3, 1'b0, "ctrl_en_rxirq");
        chk("uart_en_on", {31'b0, uart_en}, 32'd1);
        rx(8'hA5);
        rx(8'h5A);
        rd(4'd3, 32'h21, 1'b0, "status_two");
        chk("irq_rx", {31'b0, irq}, 32'd1);
        rd(4'd2, 32'hA5, 1'b0, "rx_first");
        rd(4'd2, 32'h5A, 1'b0, "rx_second");
        rd(4'd2, 32'h00, 1'b1, "rx_empty_read");
        rd(4'd3, 32'h00, 1'b0, "status_empty");
        chk("irq_rx_clear", {31'b0, irq}, 32'd0);

        // Overrun
        for (int unsigned i = 1; i <= 5; i++) rx(8'(i));
        rd(4'd3, 32'h47, 1'b0, "status_overrun");
        chk("irq_overrun", {31'b0, irq}, 32'd1);
        rd(4'd2, 32'h01, 1'b0, "ovr_rd1");
        rd(4'd2, 32'h02, 1'b0, "ovr_rd2");
        rd(4'd2, 32'h03, 1'b0, "ovr_rd3");
        rd(4'd2, 32'h04, 1'b0, "ovr_rd4");
        rd(4'd3, 32'h04, 1'b0, "status_ovr_sticky");
        wr(4'd3, 32'h4, 1'b0, "status_w1c");
        rd(4'd3, 32'h00, 1'b0, "status_ovr_cleared");

        // Full FIFO with coincident push and pop
        for (int unsigned i = 1; i <= 4; i++) rx(8'(i));
        rd(4'd3, 32'h43, 1'b0, "status_full");
        apb(1'b0, 4'd2, 32'h0, 32'h01, 1'b0, "rx_pushpop", 1'b1, 8'h99);
        rd(4'd3, 32'h43, 1'b0, "status_pushpop");
        rd(4'd2, 32'h02, 1'b0, "pp_rd2");
        rd(4'd2, 32'h03, 1'b0, "pp_rd3");
        rd(4'd2, 32'h04, 1'b0, "pp_rd4");
        rd(4'd2, 32'h99, 1'b0, "pp_rd99");
        rd(4'd3, 32'h00, 1'b0, "status_pp_empty");

        // Flush and disabled receive
        rx(8'h11);
        rx(8'h22);
        wr(4'd0, 32'hB, 1'b0, "ctrl_flush");
        rd(4'd3, 32'h00, 1'b0, "status_flushed");
        rd(4'd0, 32'h3, 1'b0, "ctrl_flush_reads0");
        wr(4'd0, 32'h0, 1'b0, "ctrl_off");
        rx(8'h77);
        rd(4'd3, 32'h00, 1'b0, "status_rx_disabled");
        chk("irq_disabled", {31'b0, irq}, 32'd0);

        // Register access errors
        wr(4'd1, 32'hFFFF_1234, 1'b0, "baud_wr");
        chk("baud_div_out", {16'b0, baud_div}, 32'h1234);
        rd(4'd1, 32'h1234, 1'b0, "baud_rd");
        rd(4'd7, 32'h0, 1'b1, "unmapped_rd");
        wr(4'd9, 32'hFFFF_FFFF, 1'b1, "unmapped_wr");
        wr(4'd2, 32'h55, 1'b1, "rxdata_wr");
        rd(4'd4, 32'h0, 1'b1, "txdata_rd");
        wr(4'd4, 32'hAA, 1'b1, "tx_while_disabled");
        rd(4'd0, 32'h0, 1'b0, "ctrl_after_errors");

        // Transmit handshake
        wr(4'd0, 32'h5, 1'b0, "ctrl_en_txirq");
        chk("irq_tx_idle", {31'b0, irq}, 32'd1);
        tx_q.push_back(8'hC3);
        wr(4'd4, 32'hC3, 1'b0, "tx_c3");
        chk("tx_start_next_cycle", {31'b0, tx_start}, 32'd1);
        chk("tx_data_c3", {24'b0, tx_data}, 32'hC3);
        chk("irq_tx_active", {31'b0, irq}, 32'd0);
        @(posedge PCLK); #1;
        tx_busy = 1'b1;
        chk("tx_start_one_cycle", {31'b0, tx_start}, 32'd0);
        rd(4'd3, 32'h08, 1'b0, "status_tx_active");
        wr(4'd4, 32'h55, 1'b1, "tx_while_busy");
        chk("tx_data_held", {24'b0, tx_data}, 32'hC3);
        tx_busy = 1'b0;
        idle(2);
        rd(4'd3, 32'h00, 1'b0, "status_tx_done");
        chk("irq_tx_done", {31'b0, irq}, 32'd1);

        // Disabling mid-transmission lets the frame finish
        tx_q.push_back(8'h5A);
        wr(4'd4, 32'h5A, 1'b0, "tx_5a");
        @(posedge PCLK); #1;
        tx_busy = 1'b1;
        wr(4'd0, 32'h0, 1'b0, "ctrl_off_midtx");
        rd(4'd3, 32'h08, 1'b0, "status_midtx");
        tx_busy = 1'b0;
        idle(2);
        rd(4'd3, 32'h00, 1'b0, "status_midtx_done");

        // Reset during transmission
        wr(4'd0, 32'h1, 1'b0, "ctrl_en_pre_rst");
        wr(4'd1, 32'd100, 1'b0, "baud_pre_rst");
        rx(8'h66);
        tx_q.push_back(8'h3C);
        wr(4'd4, 32'h3C, 1'b0, "tx_3c");
        @(posedge PCLK); #1;
        tx_busy = 1'b1;
        idle(3);
        rd(4'd3, 32'h19, 1'b0, "status_pre_rst");
        PRESET = 1'b1;
        idle(1);
        PRESET = 1'b0;
        chk("rst_midtx_baud_div", {16'b0, baud_div}, 32'd27);
        chk("rst_midtx_tx_start", {31'b0, tx_start}, 32'd0);
        chk("rst_midtx_uart_en", {31'b0, uart_en}, 32'd0);
        rd(4'd3, 32'h00, 1'b0, "rst_midtx_status");
        rd(4'd1, 32'd27, 1'b0, "rst_midtx_baud");
        tx_busy = 1'b0;
        idle(3);

        chk("apb_queue_drained", apb_q.size(), 32'd0);
        chk("tx_queue_drained", tx_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
